// File: rtl/bound_flasher_gen.sv
// Parametrised thermometer-bar flasher: three sweeps per flick, with kick-back at the P1/P2 peaks.
// Defining BOUND_FLASHER_PAUSE_EN adds a pause input that freezes the prescaler and the pattern.
module bound_flasher_gen #(
  parameter int N_LED    = 16,
  parameter int P1       = 5,
  parameter int P2       = 10,
  parameter int FLOOR    = 4,
  parameter int TICK_DIV = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flick,
`ifdef BOUND_FLASHER_PAUSE_EN
  input  logic             pause,
`endif
  output logic [N_LED-1:0] led,
  output logic             busy,
  output logic [2:0]       phase
);

  localparam int LW = $clog2(N_LED) + 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    UP1  = 3'd1,
    DN1  = 3'd2,
    UP2  = 3'd3,
    DN2  = 3'd4,
    UP3  = 3'd5,
    DN3  = 3'd6
  } phase_e;

  localparam logic signed [LW-1:0] LVL_NONE  = '1;
  localparam logic signed [LW-1:0] LVL_ZERO  = '0;
  localparam logic signed [LW-1:0] LVL_ONE   = LW'(1);
  localparam logic signed [LW-1:0] LVL_P1    = LW'(P1);
  localparam logic signed [LW-1:0] LVL_P2    = LW'(P2);
  localparam logic signed [LW-1:0] LVL_FLOOR = LW'(FLOOR);
  localparam logic signed [LW-1:0] LVL_TOP   = LW'(N_LED - 1);
  localparam logic [15:0]          DIV_TOP   = 16'(TICK_DIV - 1);

  if (N_LED < 4 || N_LED > 64 || TICK_DIV < 1 || TICK_DIV > 65535 ||
      FLOOR < 0 || FLOOR >= P1 || P1 >= P2 || P2 >= N_LED - 1) begin : g_bad_cfg
    $error("bound_flasher_gen: illegal parameter set");
  end

  logic                 pause_s;
  logic                 step_s;
  logic                 kick_s;
  logic [15:0]          cnt_q, cnt_d;
  logic signed [LW-1:0] lvl_q, lvl_d;
  phase_e               phase_q, phase_d;
  logic [N_LED-1:0]     led_s;

`ifdef BOUND_FLASHER_PAUSE_EN
  assign pause_s = pause;
`else
  assign pause_s = 1'b0;
`endif

  // Free-running prescaler; frozen only while paused
  always_comb begin
    cnt_d  = cnt_q;
    step_s = 1'b0;
    if (pause_s) begin
      cnt_d = cnt_q;
    end else if (cnt_q == DIV_TOP) begin
      cnt_d  = 16'd0;
      step_s = 1'b1;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  assign kick_s = flick && ((lvl_q == LVL_P1) || (lvl_q == LVL_P2));

  // Sweep sequencing; an illegal phase recovers to IDLE without waiting for a step
  always_comb begin
    lvl_d   = lvl_q;
    phase_d = phase_q;
    case (phase_q)
      IDLE: begin
        if (step_s && flick) begin
          lvl_d   = LVL_ZERO;
          phase_d = UP1;
        end else begin
          lvl_d   = lvl_q;
        end
      end
      UP1: begin
        if (!step_s) begin
          lvl_d = lvl_q;
        end else if (lvl_q < LVL_P1) begin
          lvl_d = lvl_q + LVL_ONE;
        end else begin
          lvl_d   = lvl_q - LVL_ONE;
          phase_d = DN1;
        end
      end
      DN1: begin
        if (!step_s) begin
          lvl_d = lvl_q;
        end else if (lvl_q >= LVL_ZERO) begin
          lvl_d = lvl_q - LVL_ONE;
        end else begin
          lvl_d   = LVL_ZERO;
          phase_d = UP2;
        end
      end
      UP2: begin
        if (!step_s) begin
          lvl_d = lvl_q;
        end else if (kick_s) begin
          lvl_d   = lvl_q - LVL_ONE;
          phase_d = DN1;
        end else if (lvl_q == LVL_P2) begin
          lvl_d   = lvl_q - LVL_ONE;
          phase_d = DN2;
        end else begin
          lvl_d = lvl_q + LVL_ONE;
        end
      end
      DN2: begin
        if (!step_s) begin
          lvl_d = lvl_q;
        end else if (lvl_q > LVL_FLOOR) begin
          lvl_d = lvl_q - LVL_ONE;
        end else begin
          lvl_d   = lvl_q + LVL_ONE;
          phase_d = UP3;
        end
      end
      UP3: begin
        if (!step_s) begin
          lvl_d = lvl_q;
        end else if (kick_s) begin
          lvl_d   = lvl_q - LVL_ONE;
          phase_d = DN2;
        end else if (lvl_q == LVL_TOP) begin
          lvl_d   = lvl_q - LVL_ONE;
          phase_d = DN3;
        end else begin
          lvl_d = lvl_q + LVL_ONE;
        end
      end
      DN3: begin
        if (!step_s) begin
          lvl_d = lvl_q;
        end else if (lvl_q > LVL_ZERO) begin
          lvl_d = lvl_q - LVL_ONE;
        end else begin
          lvl_d   = LVL_NONE;
          phase_d = IDLE;
        end
      end
      default: begin
        lvl_d   = LVL_NONE;
        phase_d = IDLE;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 16'd0;
      lvl_q   <= LVL_NONE;
      phase_q <= IDLE;
    end else begin
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      phase_q <= phase_d;
    end
  end

  // Thermometer decode: lamp i lit when i <= lvl, so lvl = -1 gives a dark bar
  always_comb begin
    led_s = '0;
    for (int i = 0; i < N_LED; i++) begin
      if (int'(lvl_q) >= i) begin
        led_s[i] = 1'b1;
      end else begin
        led_s[i] = 1'b0;
      end
    end
  end

  assign led   = led_s;
  assign busy  = (phase_q != IDLE);
  assign phase = phase_q;

endmodule

// File: tb/tb_bound_flasher_gen.sv
// Randomised bench for bound_flasher_gen: two configurations checked against a trajectory-plan model.
module tb_bound_flasher_gen;

  localparam int NA = 16, P1A = 5, P2A = 10, FA = 4, TA = 1;
  localparam int NB = 8,  P1B = 2, P2B = 4,  FB = 1, TB = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flick_a = 1'b0, flick_b = 1'b0;
  logic [NA-1:0] led_a;
  logic [NB-1:0] led_b;
  logic          busy_a, busy_b;
  logic [2:0]    phase_a, phase_b;

  always #5 clk = ~clk;

  bound_flasher_gen #(.N_LED(NA), .P1(P1A), .P2(P2A), .FLOOR(FA), .TICK_DIV(TA)) dut_a (
    .clk(clk), .rst_n(rst_n), .flick(flick_a),
`ifdef BOUND_FLASHER_PAUSE_EN
    .pause(1'b0),
`endif
    .led(led_a), .busy(busy_a), .phase(phase_a));

  bound_flasher_gen #(.N_LED(NB), .P1(P1B), .P2(P2B), .FLOOR(FB), .TICK_DIV(TB)) dut_b (
    .clk(clk), .rst_n(rst_n), .flick(flick_b),
`ifdef BOUND_FLASHER_PAUSE_EN
    .pause(1'b0),
`endif
    .led(led_b), .busy(busy_b), .phase(phase_b));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: the current level/phase plus a plan of the levels still to come
  int cfg_n[2], cfg_p1[2], cfg_p2[2], cfg_fl[2], cfg_td[2];
  int cnt[2], cur_lvl[2], cur_ph[2], plen[2], ppos[2];
  int plan_lvl[2][256];
  int plan_ph[2][256];
  int busy_cnt_a, busy_cnt_b;

  task automatic push(input int k, input int from, input int to, input int ph);
    int d = (to >= from) ? 1 : -1;
    for (int v = from; v != to + d; v += d) begin
      plan_lvl[k][plen[k]] = v;
      plan_ph[k][plen[k]]  = ph;
      plen[k]++;
    end
  endtask

  task automatic model_reset(input int k);
    cnt[k] = 0; cur_lvl[k] = -1; cur_ph[k] = 0; plen[k] = 0; ppos[k] = 0;
  endtask

  task automatic model_clk(input int k, input bit fl);
    bit stp = (cnt[k] == cfg_td[k] - 1);
    cnt[k] = stp ? 0 : cnt[k] + 1;
    if (!stp) return;
    if (cur_ph[k] == 0) begin
      if (!fl) return;
      plen[k] = 0; ppos[k] = 0;
      push(k, 0, cfg_p1[k], 1);
      push(k, cfg_p1[k] - 1, -1, 2);
      push(k, 0, cfg_p2[k], 3);
      push(k, cfg_p2[k] - 1, cfg_fl[k], 4);
      push(k, cfg_fl[k] + 1, cfg_n[k] - 1, 5);
      push(k, cfg_n[k] - 2, 0, 6);
    end else if (fl && (cur_ph[k] == 3 || cur_ph[k] == 5) &&
                 (cur_lvl[k] == cfg_p1[k] || cur_lvl[k] == cfg_p2[k])) begin
      plen[k] = 0; ppos[k] = 0;
      if (cur_ph[k] == 3) begin
        push(k, cur_lvl[k] - 1, -1, 2);
        push(k, 0, cfg_p2[k], 3);
        push(k, cfg_p2[k] - 1, cfg_fl[k], 4);
      end else begin
        push(k, cur_lvl[k] - 1, cfg_fl[k], 4);
      end
      push(k, cfg_fl[k] + 1, cfg_n[k] - 1, 5);
      push(k, cfg_n[k] - 2, 0, 6);
    end
    if (ppos[k] < plen[k]) begin
      cur_lvl[k] = plan_lvl[k][ppos[k]];
      cur_ph[k]  = plan_ph[k][ppos[k]];
      ppos[k]++;
    end else begin
      cur_lvl[k] = -1;
      cur_ph[k]  = 0;
    end
  endtask

  function automatic logic [63:0] exp_led(input int k);
    logic [63:0] r = '0;
    for (int i = 0; i < cfg_n[k]; i++) if (cur_lvl[k] >= i) r[i] = 1'b1;
    return r;
  endfunction

  task automatic compare_all();
    check("led_a",   64'(led_a),   exp_led(0));
    check("phase_a", 64'(phase_a), 64'(cur_ph[0]));
    check("busy_a",  64'(busy_a),  64'(cur_ph[0] != 0));
    check("led_b",   64'(led_b),   exp_led(1));
    check("phase_b", 64'(phase_b), 64'(cur_ph[1]));
    check("busy_b",  64'(busy_b),  64'(cur_ph[1] != 0));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_clk(0, flick_a);
    model_clk(1, flick_b);
    #1;
    compare_all();
    if (busy_a) busy_cnt_a++;
    if (busy_b) busy_cnt_b++;
    if (cur_ph[0] == 1 && cur_lvl[0] == P1A) check("peak1_a", 64'(led_a), 64'h003F);
    if (cur_lvl[0] == NA - 1)                check("top_a",   64'(led_a), 64'hFFFF);
    if (cur_ph[1] == 1 && cur_lvl[1] == P1B) check("peak1_b", 64'(led_b), 64'h07);
    if (cur_ph[1] == 3 && cur_lvl[1] == P2B) check("peak2_b", 64'(led_b), 64'h1F);
    if (cur_ph[1] == 4 && cur_lvl[1] == FB)  check("floor_b", 64'(led_b), 64'h03);
    if (cur_lvl[1] == NB - 1)                check("top_b",   64'(led_b), 64'hFF);
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while ((cur_ph[0] != 0 || cur_ph[1] != 0) && n < budget) begin
      cycle();
      n++;
    end
    check("idle_timeout", 64'(n < budget), 64'd1);
  endtask

  initial begin
    int n;
    int kicks;
    bit saw_dn2;
    logic [2:0] prev_ph;

    cfg_n  = '{NA, NB};  cfg_p1 = '{P1A, P1B}; cfg_p2 = '{P2A, P2B};
    cfg_fl = '{FA, FB};  cfg_td = '{TA, TB};
    model_reset(0);
    model_reset(1);

    #12;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) cycle();

    // TICK_DIV=3: a flick that is gone before the step edge is ignored
    while (cnt[1] == TB - 1) cycle();
    flick_b = 1'b1;
    cycle();
    flick_b = 1'b0;
    check("b_offstep_flick_idle", 64'(phase_b), 64'd0);

    // Full run on both configurations, no flick after the start
    busy_cnt_a = 0;
    busy_cnt_b = 0;
    flick_a = 1'b1;
    flick_b = 1'b1;
    cycle();
    flick_a = 1'b0;
    n = 0;
    while (cur_ph[1] == 0 && n < 10) begin cycle(); n++; end
    flick_b = 1'b0;
    run_until_idle(500);
    check("busy_len_a", 64'(busy_cnt_a),
          64'(2 * (P1A + 1) + (P2A + 1) + (P2A - FA) + (NA - 1 - FA) + (NA - 1)));
    check("busy_len_b", 64'(busy_cnt_b),
          64'(TB * (2 * (P1B + 1) + (P2B + 1) + (P2B - FB) + (NB - 1 - FB) + (NB - 1))));

    // Kick-back in UP2: held flick keeps the pattern bouncing between DN1 and UP2
    flick_a = 1'b1;
    kicks = 0;
    saw_dn2 = 1'b0;
    prev_ph = phase_a;
    repeat (120) begin
      cycle();
      if (phase_a == 3'd4) saw_dn2 = 1'b1;
      if (prev_ph == 3'd3 && phase_a == 3'd2) kicks++;
      prev_ph = phase_a;
    end
    check("kick2_no_dn2", 64'(saw_dn2), 64'd0);
    check("kick2_seen", 64'(kicks >= 3), 64'd1);
    flick_a = 1'b0;
    run_until_idle(500);

    // Kick-back in UP3 at P2
    flick_a = 1'b1;
    cycle();
    flick_a = 1'b0;
    n = 0;
    while (!(cur_ph[0] == 5 && cur_lvl[0] == P2A) && n < 200) begin cycle(); n++; end
    check("kick3_reach", 64'(n < 200), 64'd1);
    flick_a = 1'b1;
    cycle();
    flick_a = 1'b0;
    check("kick3_phase", 64'(phase_a), 64'd4);
    check("kick3_led", 64'(led_a), 64'h03FF);
    run_until_idle(500);

    // Random flick traffic on both instances
    repeat (1500) begin
      flick_a = ($urandom_range(0, 7) == 0);
      flick_b = ($urandom_range(0, 5) == 0);
      cycle();
    end
    flick_a = 1'b0;
    flick_b = 1'b0;
    run_until_idle(2000);

    // Asynchronous reset in the middle of UP2
    flick_a = 1'b1;
    cycle();
    flick_a = 1'b0;
    n = 0;
    while (!(cur_ph[0] == 3 && cur_lvl[0] == 7) && n < 100) begin cycle(); n++; end
    check("rst_reach", 64'(n < 100), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_led_a",   64'(led_a),   64'd0);
    check("rst_phase_a", 64'(phase_a), 64'd0);
    check("rst_busy_a",  64'(busy_a),  64'd0);
    model_reset(0);
    model_reset(1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) cycle();
    check("post_rst_idle", 64'(busy_a), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
